pci_arbiter: RTL and testbench
==============================

# pci_arbiter

Central bus arbiter for the 8-master PCI bus (masters A–H, index 0–7). It sits directly upstream of the master devices inside the PCI top level: it consumes their active-low `REQ_N` lines and observes `FRAME_N`/`IRDY_N` to track bus ownership. It drives one active-low `GNT_N` per master. Selectable arbitration policy, dead-master timeout, and optional bus parking.

## Interface
- `N_MASTERS`, 8, number of request/grant pairs (index width = 3)
- `GNT_TIMEOUT`, 16, clocks a granted master has to assert `FRAME_N` before the grant is revoked
- `PARK_MASTER`, 0, index parked on when idle (used only with the parking macro)

- `CLK`  in  1  bus clock; all logic on rising edge
- `RST_N`  in  1  reset, synchronous, active-low
- `REQ_N`  in  8  per-master request, active-low
- `MODE`  in  2  policy: 00 rotating, 01 fixed (A highest), 10 fixed (H highest), 11 = rotating
- `FRAME_N`  in  1  bus FRAME#, active-low
- `IRDY_N`  in  1  bus IRDY#, active-low
- `GNT_N`  out  8  per-master grant, active-low, at most one bit low
- `GNT_IDX`  out  3  index of current/last grantee
- `GNT_VALID`  out  1  high while any `GNT_N` bit is low
- `BUS_IDLE`  out  1  registered (`FRAME_N` & `IRDY_N`)

## Operation
- FSM states:
  - IDLE: no grant.
    - Any `REQ_N` bit low → register winner, drive its `GNT_N` low, → GRANT.
  - GRANT: timeout counter runs.
    - `FRAME_N` low with `IRDY_N` high → OWNED.
    - Grantee releases `REQ_N` before `FRAME_N` → drop grant, → TURN.
    - Counter reaches `GNT_TIMEOUT` → drop grant, → TURN; that master is placed lowest in rotation.
  - OWNED: grant held while `FRAME_N` low.
    - `FRAME_N` high (last data phase) → `GNT_N` all high next cycle.
    - Stay until `FRAME_N` and `IRDY_N` both high → TURN.
  - TURN: exactly one cycle, all `GNT_N` high (turnaround); rotation pointer = grantee+1 mod 8; → IDLE.
- Rotating mode: search starts at the pointer, ascending and wrapping 7→0.
- Fixed modes ignore the pointer, but the pointer still updates.
- `MODE` is sampled only in IDLE. A change mid-transaction takes effect at the next arbitration.
- Simultaneous requests resolve in the same cycle. There is no combinational path from `REQ_N` to `GNT_N`.
- Reset values: `GNT_N`=8'hFF, `GNT_IDX`=0, `GNT_VALID`=0, `BUS_IDLE`=1, state IDLE, pointer 0, timeout counter 0.
- Reset asserted in any state returns to reset values at the next edge. A grant is never held across reset.

## Timing
- Request latency: `REQ_N[w]` sampled low in IDLE at edge k → `GNT_N[w]` low after edge k (1 cycle).
- Release: `FRAME_N` sampled high in OWNED at edge k → `GNT_N` high after edge k.
- Back-to-back: minimum 1 TURN cycle plus 1 IDLE cycle between grants to different masters.
- Timeout: grant issued at edge k, no `FRAME_N` → `GNT_N` high after edge k+`GNT_TIMEOUT`.
- The counter is 5 bits, saturating, and clears on entry to GRANT.

## Configuration
- `PCI_ARB_PARK_EN` defined:
  - In IDLE with no requests, `GNT_N[PARK_MASTER]` is driven low and `GNT_VALID`=1.
  - If the parked master asserts `FRAME_N`, the FSM goes directly to OWNED with no arbitration cycle.
  - Any other request → one cycle of all-high `GNT_N`, then normal arbitration.
- Not defined: all `GNT_N` are high in IDLE.

## Structure
- Package `pci_arb_pkg`: state enum (IDLE, GRANT, OWNED, TURN), `MODE` encodings, `N_MASTERS`, index width.
- Sub-module `pci_arb_picker`: combinational. Takes request vector, start pointer and mode; returns winner index and found flag.
- FSM, pointer, and timeout counter live in `pci_arbiter`.

## Test plan
- Reset:
  - Hold `RST_N`=0 for 2 cycles with `REQ_N`=8'h00 → `GNT_N`=8'hFF, `GNT_VALID`=0.
  - Release → `GNT_N`=8'hFE one cycle later.
- Single transaction (`MODE`=00):
  - `REQ_N`=8'b1111_1110 → `GNT_N`=8'b1111_1110 next cycle.
  - `FRAME_N` low for 8 cycles, then high; `IRDY_N` high one cycle later → `GNT_N`=8'hFF, one TURN cycle.
- Rotation:
  - `REQ_N`=8'b1110_1110 held constant → grant order A, E, A, E across four transactions.
- Fixed priority:
  - `MODE`=01, `REQ_N`=8'b1111_0011 held → C (idx 2) granted every time.
  - `MODE`=10 → D (idx 3) granted every time.
- Timeout:
  - `REQ_N`=8'b1111_0111, `FRAME_N` never asserted → `GNT_N`=8'hFF after 16 cycles, TURN.
  - With A also requesting → A granted next.
- Mid-transaction reset:
  - `RST_N`=0 in OWNED with `FRAME_N` low → `GNT_N`=8'hFF next edge, state IDLE, pointer 0.

Source files
------------

// File: rtl/pci_arb_pkg.sv
// Shared types and constants for the 8-master PCI bus arbiter.
// PARK_MASTER is consulted only when PCI_ARB_PARK_EN is defined.
package pci_arb_pkg;

   localparam int N_MASTERS       = 8;
   localparam int IDX_W           = 3;
   localparam int CNT_W           = 5;
   localparam int DEF_GNT_TIMEOUT = 16;
   localparam int PARK_MASTER     = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_OWNED = 2'd2,
      ST_TURN  = 2'd3
   } arb_state_e;

   typedef enum logic [1:0] {
      MODE_ROT     = 2'b00,
      MODE_FIX_LO  = 2'b01,
      MODE_FIX_HI  = 2'b10,
      MODE_ROT_ALT = 2'b11
   } arb_mode_e;

   // Active-low one-cold grant vector for a master index.
   function automatic logic [N_MASTERS-1:0] idx_to_gnt_n(input logic [IDX_W-1:0] idx);
      logic [N_MASTERS-1:0] g;
      g      = {N_MASTERS{1'b1}};
      g[idx] = 1'b0;
      return g;
   endfunction

endpackage

// File: rtl/pci_arbiter_if.sv
// Request/grant and bus-observation signals between the arbiter and the masters.
// master modport = arbiter side, slave modport = master devices / bus side.
interface pci_arbiter_if;
   import pci_arb_pkg::*;

   logic [N_MASTERS-1:0] REQ_N;
   logic [1:0]           MODE;
   logic                 FRAME_N;
   logic                 IRDY_N;
   logic [N_MASTERS-1:0] GNT_N;
   logic [IDX_W-1:0]     GNT_IDX;
   logic                 GNT_VALID;
   logic                 BUS_IDLE;

   modport master (
      input  REQ_N, MODE, FRAME_N, IRDY_N,
      output GNT_N, GNT_IDX, GNT_VALID, BUS_IDLE
   );

   modport slave (
      output REQ_N, MODE, FRAME_N, IRDY_N,
      input  GNT_N, GNT_IDX, GNT_VALID, BUS_IDLE
   );

endinterface

// File: rtl/pci_arb_picker.sv
// Combinational winner selection: rotating from a start pointer, or fixed
// priority with A (index 0) or H (index 7) highest.
module pci_arb_picker
   import pci_arb_pkg::*;
(
   input  logic [N_MASTERS-1:0] req_i,
   input  logic [IDX_W-1:0]     ptr_i,
   input  logic [1:0]           mode_i,
   output logic [IDX_W-1:0]     win_o,
   output logic                 found_o
);

   logic [IDX_W-1:0] cand_s;

   // Loops scan from lowest to highest priority so the last hit wins.
   always_comb begin
      win_o   = {IDX_W{1'b0}};
      found_o = 1'b0;
      cand_s  = {IDX_W{1'b0}};
      case (mode_i)
         MODE_FIX_LO: begin
            for (int i = N_MASTERS - 1; i >= 0; i--) begin
               if (req_i[i]) begin
                  win_o   = IDX_W'(i);
                  found_o = 1'b1;
               end else begin
                  found_o = found_o;
               end
            end
         end
         MODE_FIX_HI: begin
            for (int i = 0; i < N_MASTERS; i++) begin
               if (req_i[i]) begin
                  win_o   = IDX_W'(i);
                  found_o = 1'b1;
               end else begin
                  found_o = found_o;
               end
            end
         end
         default: begin
            for (int i = N_MASTERS - 1; i >= 0; i--) begin
               cand_s = ptr_i + IDX_W'(i);
               if (req_i[cand_s]) begin
                  win_o   = cand_s;
                  found_o = 1'b1;
               end else begin
                  found_o = found_o;
               end
            end
         end
      endcase
   end

endmodule

// File: rtl/pci_arbiter.sv
// Central PCI bus arbiter: IDLE/GRANT/OWNED/TURN FSM, rotation pointer and
// dead-master timeout. Optional bus parking is enabled by PCI_ARB_PARK_EN.
module pci_arbiter
   import pci_arb_pkg::*;
#(
   parameter int GNT_TIMEOUT = DEF_GNT_TIMEOUT
)(
   input  logic          CLK,
   input  logic          RST_N,
   pci_arbiter_if.master bus
);

   arb_state_e           state_q, state_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [N_MASTERS-1:0] gnt_n_q, gnt_n_d;
   logic [IDX_W-1:0]     gnt_idx_q, gnt_idx_d;
   logic                 gnt_valid_q, gnt_valid_d;
   logic                 bus_idle_q, bus_idle_d;

   logic [N_MASTERS-1:0] req_s;
   logic [IDX_W-1:0]     win_s;
   logic                 found_s;
   logic [CNT_W-1:0]     cnt_inc_s;
   logic                 timeout_s;

   assign req_s     = ~bus.REQ_N;
   assign cnt_inc_s = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 5'd1;
   assign timeout_s = (cnt_inc_s >= CNT_W'(GNT_TIMEOUT));

   pci_arb_picker u_picker (
      .req_i   (req_s),
      .ptr_i   (ptr_q),
      .mode_i  (bus.MODE),
      .win_o   (win_s),
      .found_o (found_s)
   );

   // State register and registered outputs; reset never keeps a grant.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q     <= ST_IDLE;
         ptr_q       <= 3'd0;
         cnt_q       <= 5'd0;
         gnt_n_q     <= 8'hFF;
         gnt_idx_q   <= 3'd0;
         gnt_valid_q <= 1'b0;
         bus_idle_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         gnt_n_q     <= gnt_n_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_valid_q <= gnt_valid_d;
         bus_idle_q  <= bus_idle_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      gnt_n_d    = gnt_n_q;
      gnt_idx_d  = gnt_idx_q;
      bus_idle_d = bus.FRAME_N & bus.IRDY_N;
      case (state_q)
         ST_IDLE: begin
`ifdef PCI_ARB_PARK_EN
            if (gnt_valid_q) begin
               // Parked: the parked master may start without arbitrating.
               if (!bus.FRAME_N) begin
                  state_d = ST_OWNED;
               end else if (found_s && (win_s == IDX_W'(PARK_MASTER))) begin
                  cnt_d   = 5'd0;
                  state_d = ST_GRANT;
               end else if (found_s) begin
                  gnt_n_d = 8'hFF;
               end else begin
                  gnt_n_d = gnt_n_q;
               end
            end else if (found_s) begin
               gnt_n_d   = idx_to_gnt_n(win_s);
               gnt_idx_d = win_s;
               cnt_d     = 5'd0;
               state_d   = ST_GRANT;
            end else begin
               gnt_n_d   = idx_to_gnt_n(IDX_W'(PARK_MASTER));
               gnt_idx_d = IDX_W'(PARK_MASTER);
            end
`else
            if (found_s) begin
               gnt_n_d   = idx_to_gnt_n(win_s);
               gnt_idx_d = win_s;
               cnt_d     = 5'd0;
               state_d   = ST_GRANT;
            end else begin
               gnt_n_d = 8'hFF;
            end
`endif
         end
         ST_GRANT: begin
            cnt_d = cnt_inc_s;
            if (!bus.FRAME_N && bus.IRDY_N) begin
               state_d = ST_OWNED;
            end else if (!req_s[gnt_idx_q] || timeout_s) begin
               gnt_n_d = 8'hFF;
               state_d = ST_TURN;
            end else begin
               state_d = ST_GRANT;
            end
         end
         ST_OWNED: begin
            // Grant drops on the last data phase; bus is released once IRDY# also rises.
            if (bus.FRAME_N) begin
               gnt_n_d = 8'hFF;
            end else begin
               gnt_n_d = gnt_n_q;
            end
            if (bus.FRAME_N && bus.IRDY_N) begin
               state_d = ST_TURN;
            end else begin
               state_d = ST_OWNED;
            end
         end
         ST_TURN: begin
            gnt_n_d = 8'hFF;
            ptr_d   = gnt_idx_q + 3'd1;
            state_d = ST_IDLE;
         end
         default: begin
            gnt_n_d = 8'hFF;
            state_d = ST_IDLE;
         end
      endcase
      gnt_valid_d = ~(&gnt_n_d);
   end

   assign bus.GNT_N     = gnt_n_q;
   assign bus.GNT_IDX   = gnt_idx_q;
   assign bus.GNT_VALID = gnt_valid_q;
   assign bus.BUS_IDLE  = bus_idle_q;

endmodule

// File: tb/tb_pci_arbiter.sv
// Directed self-checking bench for pci_arbiter (default build, no parking).
module tb_pci_arbiter;

   logic CLK = 1'b0;
   logic RST_N;
   int   tests_run    = 0;
   int   tests_failed = 0;

   always #5 CLK = ~CLK;

   pci_arbiter_if bus ();

   pci_arbiter #(.GNT_TIMEOUT(16)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      tests_run++;
      assert (obs === exp_v) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_gnt(input string tag, input logic [7:0] gnt, input logic [2:0] idx);
      chk({tag, ".gnt_n"}, bus.GNT_N, gnt);
      chk({tag, ".valid"}, {7'd0, bus.GNT_VALID}, {7'd0, (gnt != 8'hFF)});
      chk({tag, ".idx"}, {5'd0, bus.GNT_IDX}, {5'd0, idx});
   endtask

   // Short transaction from GRANT: one data phase, release, TURN, IDLE.
   task automatic finish_txn(input string tag, input logic [7:0] gnt, input logic [2:0] idx);
      bus.FRAME_N = 1'b0;
      step();
      chk({tag, ".owned"}, bus.GNT_N, gnt);
      bus.FRAME_N = 1'b1;
      step();
      chk_gnt({tag, ".turn"}, 8'hFF, idx);
      step();
      chk({tag, ".idle"}, bus.GNT_N, 8'hFF);
   endtask

   initial begin
      RST_N       = 1'b0;
      bus.REQ_N   = 8'h00;
      bus.MODE    = 2'b00;
      bus.FRAME_N = 1'b1;
      bus.IRDY_N  = 1'b1;
      step();
      step();
      chk_gnt("reset", 8'hFF, 3'd0);
      chk("reset.bus_idle", {7'd0, bus.BUS_IDLE}, 8'd1);

      RST_N = 1'b1;
      step();
      chk_gnt("rst_release", 8'hFE, 3'd0);

      // Single transaction with A, eight FRAME# cycles.
      bus.REQ_N   = 8'hFE;
      bus.FRAME_N = 1'b0;
      step();
      chk("single.owned", bus.GNT_N, 8'hFE);
      chk("single.bus_idle", {7'd0, bus.BUS_IDLE}, 8'd0);
      bus.REQ_N  = 8'hFF;
      bus.IRDY_N = 1'b0;
      repeat (7) step();
      chk("single.frame8", bus.GNT_N, 8'hFE);
      bus.FRAME_N = 1'b1;
      step();
      chk_gnt("single.last", 8'hFF, 3'd0);
      chk("single.last_idle", {7'd0, bus.BUS_IDLE}, 8'd0);
      bus.IRDY_N = 1'b1;
      step();
      chk("single.turn", bus.GNT_N, 8'hFF);
      chk("single.turn_idle", {7'd0, bus.BUS_IDLE}, 8'd1);
      step();
      chk("single.idle", bus.GNT_N, 8'hFF);

      // Mid-transaction reset; pointer must come back to 0.
      bus.REQ_N = 8'hFE;
      step();
      chk_gnt("midrst.grant", 8'hFE, 3'd0);
      bus.FRAME_N = 1'b0;
      step();
      chk("midrst.owned", bus.GNT_N, 8'hFE);
      bus.REQ_N = 8'hEE;
      RST_N     = 1'b0;
      step();
      chk_gnt("midrst.reset", 8'hFF, 3'd0);
      RST_N       = 1'b1;
      bus.FRAME_N = 1'b1;
      step();
      chk_gnt("rot1", 8'hFE, 3'd0);

      // Rotation between A and E.
      finish_txn("rot1", 8'hFE, 3'd0);
      step();
      chk_gnt("rot2", 8'hEF, 3'd4);
      finish_txn("rot2", 8'hEF, 3'd4);
      step();
      chk_gnt("rot3", 8'hFE, 3'd0);
      finish_txn("rot3", 8'hFE, 3'd0);
      step();
      chk_gnt("rot4", 8'hEF, 3'd4);
      bus.REQ_N = 8'hFF;
      finish_txn("rot4", 8'hEF, 3'd4);

      // Fixed priority; mode change mid-transaction applies at next arbitration.
      bus.MODE  = 2'b01;
      bus.REQ_N = 8'hF3;
      step();
      chk_gnt("fixlo1", 8'hFB, 3'd2);
      finish_txn("fixlo1", 8'hFB, 3'd2);
      step();
      chk_gnt("fixlo2", 8'hFB, 3'd2);
      bus.MODE = 2'b10;
      finish_txn("fixlo2", 8'hFB, 3'd2);
      step();
      chk_gnt("fixhi1", 8'hF7, 3'd3);
      finish_txn("fixhi1", 8'hF7, 3'd3);
      step();
      chk_gnt("fixhi2", 8'hF7, 3'd3);
      bus.REQ_N = 8'hFF;
      finish_txn("fixhi2", 8'hF7, 3'd3);

      // Timeout: D never asserts FRAME#.
      bus.MODE  = 2'b00;
      bus.REQ_N = 8'hF7;
      step();
      chk_gnt("tmo.grant", 8'hF7, 3'd3);
      repeat (15) step();
      chk("tmo.edge15", bus.GNT_N, 8'hF7);
      step();
      chk_gnt("tmo.edge16", 8'hFF, 3'd3);
      bus.REQ_N = 8'hF6;
      step();
      chk("tmo.idle", bus.GNT_N, 8'hFF);
      step();
      chk_gnt("tmo.next", 8'hFE, 3'd0);

      // Grantee drops its request before FRAME#.
      bus.REQ_N = 8'hFF;
      step();
      chk_gnt("release.turn", 8'hFF, 3'd0);
      step();
      chk("release.idle", bus.GNT_N, 8'hFF);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
